// File: rtl/dmem_mmio.sv
// Data-side memory responder for the single-cycle mips core: word RAM plus a
// 256-byte peripheral page (cycle counter, GPIO, down-counting timer).
module dmem_mmio #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        byteread,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  gpio_out,
  output logic        timer_irq
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [5:0] OFS_CYCLE  = 6'h00;
  localparam logic [5:0] OFS_GPIO   = 6'h01;
  localparam logic [5:0] OFS_TLOAD  = 6'h02;
  localparam logic [5:0] OFS_TCOUNT = 6'h03;
  localparam logic [5:0] OFS_TCTRL  = 6'h04;

  logic [31:0] r_ram [DEPTH];
  logic [31:0] r_cycle;
  logic [7:0]  r_gpio;
  logic [31:0] r_tload;
  logic [31:0] r_tcount;
  logic        r_en;
  logic        r_auto;
  logic        r_flag;

  logic        w_ram_hit;
  logic        w_mmio_hit;
  logic [5:0]  w_ofs;
  logic        w_wr_gpio;
  logic        w_wr_tload;
  logic        w_wr_tctrl;
  logic        w_expire;
  logic [31:0] w_word;
  logic [7:0]  w_byte;

  function automatic logic signed [31:0] sext_byte(input logic signed [7:0] b);
    return 32'(b);
  endfunction

  assign w_ram_hit  = (a[31:AW+2] == '0);
  assign w_mmio_hit = (a[31:8] == MMIO_BASE[31:8]);
  assign w_ofs      = a[7:2];

  assign w_wr_gpio  = we && w_mmio_hit && (w_ofs == OFS_GPIO);
  assign w_wr_tload = we && w_mmio_hit && (w_ofs == OFS_TLOAD);
  assign w_wr_tctrl = we && w_mmio_hit && (w_ofs == OFS_TCTRL);

  // Expiry only when counting and not overridden by a reload write this edge.
  assign w_expire   = r_en && !w_wr_tload && (r_tcount == '0);

  always_ff @(posedge clk) begin
    if (!reset && we && w_ram_hit)
      r_ram[a[AW+1:2]] <= wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle  <= '0;
      r_gpio   <= '0;
      r_tload  <= '0;
      r_tcount <= '0;
      r_en     <= 1'b0;
      r_auto   <= 1'b0;
      r_flag   <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_wr_gpio)
        r_gpio <= wd[7:0];

      if (w_wr_tload) begin
        r_tload  <= wd;
        r_tcount <= wd;
      end else if (r_en) begin
        if (r_tcount != '0)
          r_tcount <= r_tcount - 32'd1;
        else if (r_auto)
          r_tcount <= r_tload;
      end

      // A written EN/AUTO overrides the one-shot self-disable.
      if (w_wr_tctrl) begin
        r_en   <= wd[0];
        r_auto <= wd[1];
      end else if (w_expire && !r_auto) begin
        r_en <= 1'b0;
      end

      if (w_expire)
        r_flag <= 1'b1;
      else if (w_wr_tctrl && wd[2])
        r_flag <= 1'b0;
    end
  end

  always_comb begin
    w_word = '0;
    if (w_ram_hit) begin
      w_word = r_ram[a[AW+1:2]];
    end else if (w_mmio_hit) begin
      case (w_ofs)
        OFS_CYCLE:  w_word = r_cycle;
        OFS_GPIO:   w_word = {24'd0, r_gpio};
        OFS_TLOAD:  w_word = r_tload;
        OFS_TCOUNT: w_word = r_tcount;
        OFS_TCTRL:  w_word = {29'd0, r_flag, r_auto, r_en};
        default:    w_word = '0;
      endcase
    end
  end

  always_comb begin
    w_byte = '0;
    case (a[1:0])
      2'd0: w_byte = w_word[7:0];
      2'd1: w_byte = w_word[15:8];
      2'd2: w_byte = w_word[23:16];
      2'd3: w_byte = w_word[31:24];
      default: w_byte = '0;
    endcase
  end

  assign rd        = byteread ? sext_byte(w_byte) : w_word;
  assign gpio_out  = r_gpio;
  assign timer_irq = r_flag;

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: stimulus queues expected values, a negedge
// monitor pops and compares them against rd / gpio_out / timer_irq.
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        byteread;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  typedef struct {
    int          sel;   // 0 = rd, 1 = gpio_out, 2 = timer_irq
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [31:0] A_CYC = 32'hFFFF_FF00;
  localparam logic [31:0] A_GPI = 32'hFFFF_FF04;
  localparam logic [31:0] A_TLD = 32'hFFFF_FF08;
  localparam logic [31:0] A_TCN = 32'hFFFF_FF0C;
  localparam logic [31:0] A_TCT = 32'hFFFF_FF10;

  dmem_mmio #(.DEPTH(64), .MMIO_BASE(32'hFFFF_FF00)) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .byteread  (byteread),
    .a         (a),
    .wd        (wd),
    .rd        (rd),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        1:       act = {24'd0, gpio_out};
        2:       act = {31'd0, timer_irq};
        default: act = rd;
      endcase
      n_chk++;
      if (act === e.exp)
        n_pass++;
      else
        $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1; byteread = 1'b0; a = addr; wd = data;
    cyc();
    we = 1'b0;
  endtask

  task automatic rdchk(input logic [31:0] addr, input logic br,
                       input logic [31:0] exp, input string name);
    exp_t e;
    we = 1'b0; byteread = br; a = addr;
    e.sel = 0; e.exp = exp; e.name = name;
    q.push_back(e);
    cyc();
    byteread = 1'b0;
  endtask

  task automatic sigchk(input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.sel = sel; e.exp = exp; e.name = name;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; we = 1'b0; byteread = 1'b0; a = '0; wd = '0;
    repeat (2) cyc();
    sigchk(1, 32'h0, "rst_gpio");
    sigchk(2, 32'h0, "rst_irq");
    rdchk(A_CYC, 1'b0, 32'h0, "rst_cycle");
    rdchk(A_TCT, 1'b0, 32'h0, "rst_tctrl");
    reset = 1'b0;

    // RAM word and byte reads
    wr(32'h20, 32'h8899_AABB);
    rdchk(32'h20, 1'b0, 32'h8899_AABB, "ram_word");
    rdchk(32'h20, 1'b1, 32'hFFFF_FFBB, "ram_b0");
    rdchk(32'h21, 1'b1, 32'hFFFF_FFAA, "ram_b1");
    rdchk(32'h22, 1'b1, 32'hFFFF_FF99, "ram_b2");
    rdchk(32'h23, 1'b1, 32'hFFFF_FF88, "ram_b3");
    rdchk(32'h22, 1'b0, 32'h8899_AABB, "ram_align");
    wr(32'h28, 32'h0000_0070);
    rdchk(32'h28, 1'b1, 32'h0000_0070, "ram_bpos");

    // Cycle counter, write dropped during reset, unmapped space
    wr(32'h24, 32'h1111_1111);
    wr(32'h00, 32'h55AA_55AA);
    reset = 1'b1;
    wr(32'h24, 32'hDEAD_BEEF);
    cyc();
    reset = 1'b0;
    repeat (10) cyc();
    rdchk(A_CYC, 1'b0, 32'd10, "cycle10");
    wr(A_CYC, 32'h1234);
    rdchk(A_CYC, 1'b0, 32'd12, "cycle_nowr");
    rdchk(32'h24, 1'b0, 32'h1111_1111, "rst_wr_drop");
    rdchk(32'h1000, 1'b0, 32'h0, "unmapped_rd");
    wr(32'h1000, 32'hCAFE_F00D);
    rdchk(32'h00, 1'b0, 32'h55AA_55AA, "unmapped_wr");
    rdchk(32'hFFFF_FF40, 1'b0, 32'h0, "mmio_hole");

    // GPIO
    wr(A_GPI, 32'hFFFF_FFA5);
    sigchk(1, 32'hA5, "gpio_out");
    rdchk(A_GPI, 1'b0, 32'h0000_00A5, "gpio_rd");
    rdchk(A_GPI, 1'b1, 32'hFFFF_FFA5, "gpio_b0");
    rdchk(32'hFFFF_FF05, 1'b1, 32'h0, "gpio_b1");

    // One-shot timer
    wr(A_TLD, 32'd3);
    wr(A_TCT, 32'd1);
    rdchk(A_TCN, 1'b0, 32'd3, "os_3");
    rdchk(A_TCN, 1'b0, 32'd2, "os_2");
    rdchk(A_TCN, 1'b0, 32'd1, "os_1");
    sigchk(2, 32'h0, "os_irq_pre");
    rdchk(A_TCN, 1'b0, 32'd0, "os_0");
    sigchk(2, 32'h1, "os_irq");
    rdchk(A_TCT, 1'b0, 32'h4, "os_tctrl");
    rdchk(A_TCN, 1'b0, 32'd0, "os_hold");

    // Auto-reload timer, FLAG set/clear races
    wr(A_TLD, 32'd2);
    wr(A_TCT, 32'd3);
    rdchk(A_TCN, 1'b0, 32'd2, "ar_2");
    rdchk(A_TCN, 1'b0, 32'd1, "ar_1");
    rdchk(A_TCN, 1'b0, 32'd0, "ar_0");
    rdchk(A_TCN, 1'b0, 32'd2, "ar_reload");
    wr(A_TCT, 32'h7);
    sigchk(2, 32'h0, "irq_clr");
    rdchk(A_TCN, 1'b0, 32'd0, "ar_0b");
    sigchk(2, 32'h1, "irq_auto");
    rdchk(A_TCN, 1'b0, 32'd2, "ar_2b");
    rdchk(A_TCN, 1'b0, 32'd1, "ar_1b");
    wr(A_TCT, 32'h7);
    sigchk(2, 32'h1, "set_wins");
    rdchk(A_TCT, 1'b0, 32'h7, "tctrl_rd");
    wr(A_TCT, 32'h7);
    sigchk(2, 32'h0, "w1c");

    // Reset mid-count with a concurrent TLOAD write
    wr(A_GPI, 32'h3C);
    wr(A_TLD, 32'd5);
    sigchk(2, 32'h1, "pre_irq");
    sigchk(1, 32'h3C, "pre_gpio");
    rdchk(A_TCN, 1'b0, 32'd5, "pre_tcount");
    reset = 1'b1;
    we = 1'b1; a = A_TLD; wd = 32'h99;
    cyc();
    we = 1'b0;
    cyc();
    reset = 1'b0;
    sigchk(1, 32'h0, "mr_gpio");
    sigchk(2, 32'h0, "mr_irq");
    rdchk(A_CYC, 1'b0, 32'h0, "mr_cycle");
    rdchk(A_TLD, 1'b0, 32'h0, "mr_tload");
    rdchk(A_TCN, 1'b0, 32'h0, "mr_tcount");
    rdchk(A_TCT, 1'b0, 32'h0, "mr_tctrl");
    rdchk(A_GPI, 1'b0, 32'h0, "mr_gpio_rd");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
